// File: rtl/jk_reg_bank_pkg.sv
// Shared mode encoding for the JK register bank and its cells.
// The 2-bit mode selects per-bit JK, up count, down count or parallel load.
package jk_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t MODE_JK = 2'b00;
    localparam jk_mode_t MODE_UP = 2'b01;
    localparam jk_mode_t MODE_DN = 2'b10;
    localparam jk_mode_t MODE_LD = 2'b11;

    // JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
    function automatic logic jk_next(input logic cur, input logic j, input logic k);
        logic nxt;
        nxt = cur;
        case ({j, k})
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = ~cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_reg_bank_cell.sv
// Single JK flip-flop with enable and asynchronous active-low reset.
// q and q_n are held in separate flops so q_n never depends combinationally on q.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    logic q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = jk_next(q, j, k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= rst_val;
            q_n <= ~rst_val;
        end else begin
            q   <= q_next;
            q_n <= ~q_next;
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with JK, up-count, down-count and load modes.
// Count modes drive each cell with j=k=toggle; a wrap pulse follows each terminal count edge.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             wrap
);

    jk_mode_t         mode_s;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             all_ones_below;
    logic             all_zeros_below;

    assign mode_s = jk_mode_t'(mode);

    // Ripple the "all lower bits are 1 / 0" conditions; bit 0 always toggles.
    always_comb begin
        up_tog          = '0;
        dn_tog          = '0;
        all_ones_below  = 1'b1;
        all_zeros_below = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_tog[i]       = all_ones_below;
            dn_tog[i]       = all_zeros_below;
            all_ones_below  = all_ones_below & q[i];
            all_zeros_below = all_zeros_below & ~q[i];
        end
    end

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode_s)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_UP: begin
                cell_j = up_tog;
                cell_k = up_tog;
            end
            MODE_DN: begin
                cell_j = dn_tog;
                cell_k = dn_tog;
            end
            default: begin
                cell_j = d;
                cell_k = ~d;
            end
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RST_VAL[gi]),
            .en      (en),
            .j       (cell_j[gi]),
            .k       (cell_k[gi]),
            .q       (q[gi]),
            .q_n     (q_n[gi])
        );
    end

    assign tc = en & (((mode_s == MODE_UP) && (q == {WIDTH{1'b1}})) ||
                      ((mode_s == MODE_DN) && (q == {WIDTH{1'b0}})));

    // tc already folds in en, so a disabled edge clears wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule
